// File: rtl/pc_call_stack_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_call_stack_pkg
// Purpose  : Shared PC/call-stack defaults and next-PC source encodings.
// Revision : 1.0 - initial release
// ============================================================================
package pc_call_stack_pkg;

    localparam int c_pc_w_default  = 10;
    localparam int c_depth_default = 8;

    // Next-PC source selector driven by the control unit
    typedef enum logic [1:0] {
        J_INC  = 2'b00,
        J_ABS  = 2'b01,
        J_RET  = 2'b10,
        J_RSVD = 2'b11
    } j_mode_e;

endpackage
`default_nettype wire

// File: rtl/pc_call_stack_stack.sv
`default_nettype none
// ============================================================================
// Module   : call_stack
// Purpose  : LIFO of return addresses with occupancy count, full and empty.
// Revision : 1.0 - initial release
// ============================================================================
module call_stack
    import pc_call_stack_pkg::*;
#(
    parameter int DATA_W = c_pc_w_default,
    parameter int DEPTH  = c_depth_default
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [DATA_W-1:0]        i_data,
    output logic [DATA_W-1:0]        o_data,
    output logic [$clog2(DEPTH):0]   o_depth,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int c_aw = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_aw:0]     r_depth;
    logic              w_full;
    logic              w_empty;
    logic              w_do_push;
    logic              w_do_pop;
    logic [c_aw-1:0]   w_top_idx;

    assign w_full    = (r_depth == (c_aw+1)'(DEPTH));
    assign w_empty   = (r_depth == '0);
    assign w_do_push = i_push & ~w_full;
    assign w_do_pop  = i_pop & ~w_empty;
    assign w_top_idx = c_aw'(r_depth - 1'b1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_depth <= '0;
        end else if (w_do_push && !w_do_pop) begin
            r_depth <= r_depth + 1'b1;
        end else if (w_do_pop && !w_do_push) begin
            r_depth <= r_depth - 1'b1;
        end
    end

    // Storage is deliberately left out of reset; depth alone defines validity
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_do_push && !w_do_pop) begin
            r_mem[r_depth[c_aw-1:0]] <= i_data;
        end
    end

    assign o_data  = w_empty ? '0 : r_mem[w_top_idx];
    assign o_depth = r_depth;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule
`default_nettype wire

// File: rtl/pc_call_stack.sv
`default_nettype none
// ============================================================================
// Module   : pc_call_stack
// Purpose  : Program counter with next-PC mux, return register and call stack.
// Revision : 1.0 - initial release
// ============================================================================
module pc_call_stack
    import pc_call_stack_pkg::*;
#(
    parameter int PC_W  = c_pc_w_default,
    parameter int DEPTH = c_depth_default
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_PCw,
    input  logic                     i_jump,
    input  logic [1:0]               i_j_mode,
    input  logic                     i_call,
    input  logic                     i_return,
    input  logic [PC_W-1:0]          i_target,
    output logic [PC_W-1:0]          o_pc,
    output logic [$clog2(DEPTH):0]   o_depth,
    output logic                     o_stack_ovf,
    output logic                     o_stack_unf,
    output logic                     o_stack_err
);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_ret;
    logic            r_ovf;
    logic            r_unf;
    logic            r_err;

    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_pc_next;
    logic [PC_W-1:0] w_stack_top;
    logic            w_conflict;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;

    assign w_pc_inc   = r_pc + 1'b1;
    assign w_conflict = i_call & i_return;
    assign w_push     = i_call & i_PCw & ~w_conflict;
    assign w_pop      = i_return & ~w_conflict;

    call_stack #(
        .DATA_W (PC_W),
        .DEPTH  (DEPTH)
    ) u_call_stack (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_pc_inc),
        .o_data  (w_stack_top),
        .o_depth (o_depth),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // RET ignores i_jump; ABS without i_jump and RSVD both fall through to increment
    always_comb begin
        w_pc_next = w_pc_inc;
        case (j_mode_e'(i_j_mode))
            J_ABS:   if (i_jump) w_pc_next = i_target;
            J_RET:   w_pc_next = r_ret;
            default: w_pc_next = w_pc_inc;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc  <= '0;
            r_ret <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            r_err <= 1'b0;
        end else begin
            if (i_PCw) begin
                r_pc <= w_pc_next;
            end
            if (w_pop) begin
                r_ret <= w_stack_top;
            end
            if (w_push && w_full) begin
                r_ovf <= 1'b1;
            end
            if (w_pop && w_empty) begin
                r_unf <= 1'b1;
            end
            if (w_conflict) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_pc        = r_pc;
    assign o_stack_ovf = r_ovf;
    assign o_stack_unf = r_unf;
    assign o_stack_err = r_err;

endmodule
`default_nettype wire
